// File: rtl/doctor_console_ctrl.sv
// Doctor's panel sequencer: arbitrates the vital-sign display between live view, history playback and alarm status.
// Optional build macro STATUS_TIMEOUT_EN adds an automatic return from the status page after SHOLD cycles.
module doctor_console_ctrl #(
  parameter int NPARAM = 4,
  parameter int SELW   = 2,
  parameter int AW     = 3,
  parameter int DWELL  = 13,
  parameter int TW     = 4,
  parameter int SHOLD  = 13
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            postop,
  input  logic            tasto_change,
  input  logic            tasto_hist,
  input  logic            tasto_status,
  input  logic [AW:0]     hist_count,
  input  logic            hist_rd_ack,
  output logic [1:0]      mode,
  output logic [SELW-1:0] sel,
  output logic            hist_rd_req,
  output logic [AW-1:0]   hist_rd_addr,
  output logic            hist_busy
);

  typedef enum logic [1:0] {M_IDLE = 2'b00, M_LIVE = 2'b01, M_HIST = 2'b10, M_STATUS = 2'b11} mode_t;
  typedef enum logic {S_REQ = 1'b0, S_DWELL = 1'b1} sub_t;

  localparam logic [SELW-1:0] SEL_LAST = SELW'(NPARAM - 1);
  localparam logic [TW-1:0]   DWELL_LD = TW'(DWELL - 1);
  localparam logic [AW:0]     ONE_CNT  = (AW + 1)'(1);

  if (NPARAM < 1 || NPARAM > 2**SELW || DWELL < 1 || DWELL > 2**TW || SHOLD < 1 || SHOLD > 2**TW)
  begin : g_param_check
    $error("doctor_console_ctrl: parameter out of range");
  end

  mode_t           r_mode;
  sub_t            r_sub;
  logic [SELW-1:0] r_sel;
  logic            r_req;
  logic [AW-1:0]   r_addr;
  logic            r_busy;
  logic [TW-1:0]   r_cnt;
  logic [AW:0]     r_hcnt;
  logic [2:0]      r_lvl;
  logic [2:0]      r_pulse;
`ifdef STATUS_TIMEOUT_EN
  logic [TW-1:0]   r_hold;
  localparam logic [TW-1:0] HOLD_LD = TW'(SHOLD - 1);
`endif

  logic [2:0] w_btn;
  logic       w_stat;
  logic       w_hist;
  logic       w_chg;
  logic       w_last;

  // Bit order {status, hist, change}; the pulse register makes each press act one cycle after the level rises.
  assign w_btn  = {tasto_status, tasto_hist, tasto_change};
  assign w_stat = r_pulse[2];
  assign w_hist = r_pulse[1] & ~r_pulse[2];
  assign w_chg  = r_pulse[0] & ~r_pulse[1] & ~r_pulse[2];
  assign w_last = ({1'b0, r_addr} == (r_hcnt - ONE_CNT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lvl   <= '0;
      r_pulse <= '0;
    end else begin
      r_pulse <= w_btn & ~r_lvl;
      r_lvl   <= w_btn;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mode <= M_IDLE;
      r_sub  <= S_REQ;
      r_sel  <= '0;
      r_req  <= 1'b0;
      r_addr <= '0;
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_hcnt <= '0;
`ifdef STATUS_TIMEOUT_EN
      r_hold <= '0;
`endif
    end else if (!postop) begin
      r_mode <= M_IDLE;
      r_busy <= 1'b0;
      r_sel  <= '0;
      r_req  <= 1'b0;
    end else begin
      case (r_mode)
        M_IDLE: r_mode <= M_LIVE;
        M_LIVE: begin
          if (w_stat) begin
            r_mode <= M_STATUS;
`ifdef STATUS_TIMEOUT_EN
            r_hold <= HOLD_LD;
`endif
          end else if (w_hist) begin
            if (hist_count != '0) begin
              r_mode <= M_HIST;
              r_busy <= 1'b1;
              r_sub  <= S_REQ;
              r_req  <= 1'b1;
              r_addr <= '0;
              r_hcnt <= hist_count;
            end
          end else if (w_chg) begin
            r_sel <= (r_sel == SEL_LAST) ? '0 : r_sel + SELW'(1);
          end
        end
        M_HIST: begin
          if (w_stat) begin
            r_mode <= M_STATUS;
            r_busy <= 1'b0;
            r_req  <= 1'b0;
`ifdef STATUS_TIMEOUT_EN
            r_hold <= HOLD_LD;
`endif
          end else if (w_hist) begin
            r_mode <= M_LIVE;
            r_busy <= 1'b0;
            r_req  <= 1'b0;
          end else if (r_sub == S_REQ) begin
            if (hist_rd_ack) begin
              r_req <= 1'b0;
              r_sub <= S_DWELL;
              r_cnt <= DWELL_LD;
            end
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - TW'(1);
          end else if (w_last) begin
            r_mode <= M_LIVE;
            r_busy <= 1'b0;
          end else begin
            r_addr <= r_addr + AW'(1);
            r_req  <= 1'b1;
            r_sub  <= S_REQ;
          end
        end
        M_STATUS: begin
          if (w_stat) begin
            r_mode <= M_LIVE;
          end
`ifdef STATUS_TIMEOUT_EN
          else if (r_hold == '0) begin
            r_mode <= M_LIVE;
          end else begin
            r_hold <= r_hold - TW'(1);
          end
`endif
        end
      endcase
    end
  end

  assign mode         = r_mode;
  assign sel          = r_sel;
  assign hist_rd_req  = r_req;
  assign hist_rd_addr = r_addr;
  assign hist_busy    = r_busy;

endmodule

// File: tb/tb_doctor_console_ctrl.sv
// Bench for doctor_console_ctrl: table-driven vectors, hand-written playback/abort/reset/status sequences,
// and randomized stimulus compared against an in-bench reference model.
module tb_doctor_console_ctrl;
  localparam int NPARAM = 4;
  localparam int SELW   = 2;
  localparam int AW     = 3;
  localparam int DWELL  = 13;
  localparam int TW     = 4;
  localparam int SHOLD  = 13;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            postop = 1'b0;
  logic            chg = 1'b0;
  logic            hst = 1'b0;
  logic            stt = 1'b0;
  logic            ack = 1'b0;
  logic [AW:0]     hcount = '0;
  logic [1:0]      mode;
  logic [SELW-1:0] sel;
  logic            req;
  logic [AW-1:0]   addr;
  logic            busy;

  int checks = 0;
  int errors = 0;

  doctor_console_ctrl #(.NPARAM(NPARAM), .SELW(SELW), .AW(AW), .DWELL(DWELL), .TW(TW), .SHOLD(SHOLD)) dut (
    .clk(clk), .rst(rst), .postop(postop),
    .tasto_change(chg), .tasto_hist(hst), .tasto_status(stt),
    .hist_count(hcount), .hist_rd_ack(ack),
    .mode(mode), .sel(sel), .hist_rd_req(req), .hist_rd_addr(addr), .hist_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_outs(input string nm, input int em, input int es, input int er);
    check({nm, "_mode"}, 32'(mode), em);
    check({nm, "_sel"},  32'(sel),  es);
    check({nm, "_req"},  32'(req),  er);
    check({nm, "_busy"}, 32'(busy), (em == 2) ? 1 : 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: one call per clock edge, with the inputs that were present at that edge.
  int       m_mode, m_sel, m_req, m_addr, m_cnt, m_hcnt, m_hold;
  bit       m_dwelling;
  bit [2:0] m_prev, m_pend;

  task automatic model_reset();
    m_mode = 0; m_sel = 0; m_req = 0; m_addr = 0; m_cnt = 0; m_hcnt = 0; m_hold = 0;
    m_dwelling = 0; m_prev = '0; m_pend = '0;
  endtask

  task automatic model_step(input bit po, input bit c, input bit h, input bit s, input int hc, input bit a);
    bit ps, ph, pc;
    ps = m_pend[2];
    ph = m_pend[1] && !ps;
    pc = m_pend[0] && !ps && !ph;
    if (!po) begin
      m_mode = 0; m_sel = 0; m_req = 0;
    end else begin
      case (m_mode)
        0: m_mode = 1;
        1: begin
          if (ps) begin
            m_mode = 3; m_hold = SHOLD - 1;
          end else if (ph) begin
            if (hc != 0) begin
              m_mode = 2; m_hcnt = hc; m_addr = 0; m_req = 1; m_dwelling = 0;
            end
          end else if (pc) begin
            m_sel = (m_sel + 1) % NPARAM;
          end
        end
        2: begin
          if (ps) begin
            m_mode = 3; m_req = 0; m_hold = SHOLD - 1;
          end else if (ph) begin
            m_mode = 1; m_req = 0;
          end else if (!m_dwelling) begin
            if (a) begin
              m_req = 0; m_dwelling = 1; m_cnt = DWELL - 1;
            end
          end else if (m_cnt > 0) begin
            m_cnt--;
          end else if (m_addr == m_hcnt - 1) begin
            m_mode = 1;
          end else begin
            m_addr++; m_req = 1; m_dwelling = 0;
          end
        end
        default: begin
          if (ps) m_mode = 1;
`ifdef STATUS_TIMEOUT_EN
          else if (m_hold == 0) m_mode = 1;
          else m_hold--;
`endif
        end
      endcase
    end
    m_pend = {s, h, c} & ~m_prev;
    m_prev = {s, h, c};
  endtask

  typedef struct {
    bit po, c, h, s;
    int hc;
    int emode, esel, ereq;
  } vec_t;
  vec_t tbl[28];

  task automatic enter_hist(input int hc, input int esel);
    hcount = (AW + 1)'(hc);
    hst = 1'b1; tick();
    hst = 1'b0; tick();
    check_outs("hist_entry", 2, esel, 1);
    check("hist_entry_addr", 32'(addr), 0);
  endtask

  // Ack arrives two cycles into each request; the entry then dwells DWELL cycles.
  task automatic serve(input int k, input bit last, input int esel);
    bit ok;
    ack = 1'b0; tick();
    check("req_wait", 32'(req), 1);
    check("req_addr", 32'(addr), k);
    ack = 1'b1; tick();
    check_outs("ack_drop", 2, esel, 0);
    ack = 1'b0;
    ok = 1'b1;
    for (int n = 1; n < DWELL; n++) begin
      tick();
      if (!(mode == 2'b10 && req == 1'b0 && addr == AW'(k))) ok = 1'b0;
    end
    check("dwell_hold", 32'(ok), 1);
    tick();
    if (last) begin
      check_outs("play_done", 1, esel, 0);
    end else begin
      check_outs("next_req", 2, esel, 1);
      check("next_addr", 32'(addr), k + 1);
    end
  endtask

  initial begin
    tbl[0]  = '{1,0,0,0,0, 1,0,0};
    tbl[1]  = '{1,1,0,0,0, 1,0,0};
    tbl[2]  = '{1,1,0,0,0, 1,1,0};
    tbl[3]  = '{1,1,0,0,0, 1,1,0};
    tbl[4]  = '{1,0,0,0,0, 1,1,0};
    tbl[5]  = '{1,1,0,0,0, 1,1,0};
    tbl[6]  = '{1,0,0,0,0, 1,2,0};
    tbl[7]  = '{1,1,0,0,0, 1,2,0};
    tbl[8]  = '{1,0,0,0,0, 1,3,0};
    tbl[9]  = '{1,1,0,0,0, 1,3,0};
    tbl[10] = '{1,0,0,0,0, 1,0,0};
    tbl[11] = '{1,1,0,0,0, 1,0,0};
    tbl[12] = '{1,0,0,0,0, 1,1,0};
    tbl[13] = '{1,0,1,0,0, 1,1,0};
    tbl[14] = '{1,0,0,0,0, 1,1,0};
    tbl[15] = '{1,1,1,1,2, 1,1,0};
    tbl[16] = '{1,0,0,0,2, 3,1,0};
    tbl[17] = '{1,1,0,0,2, 3,1,0};
    tbl[18] = '{1,0,1,0,2, 3,1,0};
    tbl[19] = '{1,0,0,0,2, 3,1,0};
    tbl[20] = '{1,0,0,1,2, 3,1,0};
    tbl[21] = '{1,0,0,0,2, 1,1,0};
    tbl[22] = '{1,1,0,0,0, 1,1,0};
    tbl[23] = '{1,0,0,0,0, 1,2,0};
    tbl[24] = '{0,0,0,0,0, 0,0,0};
    tbl[25] = '{0,0,1,0,3, 0,0,0};
    tbl[26] = '{1,0,0,0,3, 1,0,0};
    tbl[27] = '{1,0,0,0,3, 1,0,0};

    #12;
    check_outs("reset", 0, 0, 0);
    check("reset_addr", 32'(addr), 0);
    #1 rst = 1'b1;

    for (int i = 0; i < 28; i++) begin
      postop = tbl[i].po; chg = tbl[i].c; hst = tbl[i].h; stt = tbl[i].s;
      hcount = (AW + 1)'(tbl[i].hc);
      tick();
      check_outs($sformatf("vec%0d", i), tbl[i].emode, tbl[i].esel, tbl[i].ereq);
    end

    // Full playback of three entries; hist_count changes after entry must not matter.
    enter_hist(3, 0);
    hcount = (AW + 1)'(1);
    serve(0, 1'b0, 0);
    serve(1, 1'b0, 0);
    serve(2, 1'b1, 0);

    // Abort at address 1 with the ack still outstanding; change is ignored inside HIST.
    chg = 1'b1; tick(); chg = 1'b0; tick();
    check_outs("pre_abort_sel", 1, 1, 0);
    enter_hist(3, 1);
    serve(0, 1'b0, 1);
    chg = 1'b1; tick(); chg = 1'b0; tick();
    check_outs("hist_chg_ignored", 2, 1, 1);
    check("hist_chg_addr", 32'(addr), 1);
    hst = 1'b1; tick();
    check("abort_req_hold", 32'(req), 1);
    hst = 1'b0; tick();
    check_outs("abort", 1, 1, 0);

    // Status press during playback.
    enter_hist(2, 1);
    stt = 1'b1; tick(); stt = 1'b0; tick();
    check_outs("hist_to_status", 3, 1, 0);
    stt = 1'b1; tick(); stt = 1'b0; tick();
    check_outs("status_to_live", 1, 1, 0);

    // Status page dwell.
    stt = 1'b1; tick(); stt = 1'b0; tick();
    check_outs("status_enter", 3, 1, 0);
    begin
      bit ok;
      ok = 1'b1;
`ifdef STATUS_TIMEOUT_EN
      for (int n = 1; n < SHOLD; n++) begin
        tick();
        if (mode != 2'b11) ok = 1'b0;
      end
      check("status_hold", 32'(ok), 1);
      tick();
      check_outs("status_timeout", 1, 1, 0);
`else
      for (int n = 0; n < 100; n++) begin
        tick();
        if (mode != 2'b11) ok = 1'b0;
      end
      check("status_stays", 32'(ok), 1);
      stt = 1'b1; tick(); stt = 1'b0; tick();
      check_outs("status_exit", 1, 1, 0);
`endif
    end

    // Asynchronous reset in the middle of a request.
    enter_hist(2, 1);
    #2 rst = 1'b0;
    #1;
    check_outs("async_rst", 0, 0, 0);
    check("async_rst_addr", 32'(addr), 0);
    #1 rst = 1'b1;
    tick();
    check_outs("rst_release", 1, 0, 0);

    // Randomized run against the reference model.
    #2 rst = 1'b0;
    postop = 1'b0; chg = 1'b0; hst = 1'b0; stt = 1'b0; ack = 1'b0; hcount = '0;
    model_reset();
    #2 rst = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      postop = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 5) == 0)  chg = ~chg;
      if ($urandom_range(0, 24) == 0) hst = ~hst;
      if ($urandom_range(0, 39) == 0) stt = ~stt;
      if ($urandom_range(0, 9) == 0)  hcount = (AW + 1)'($urandom_range(0, 2**AW));
      ack = ($urandom_range(0, 2) == 0);
      tick();
      model_step(postop, chg, hst, stt, int'(hcount), ack);
      check("rnd_mode", 32'(mode), m_mode);
      check("rnd_sel",  32'(sel),  m_sel);
      check("rnd_req",  32'(req),  m_req);
      check("rnd_busy", 32'(busy), (m_mode == 2) ? 1 : 0);
      if (m_mode == 2) check("rnd_addr", 32'(addr), m_addr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/doctor_console_ctrl.md
Name: doctor_console_ctrl

Overview:
Sequencer for the doctor's panel in the post-op monitoring system. It takes the debounced change, history and status button levels and the post-op switch, and decides which source owns the shared vital-sign display: live view with a selected parameter, playback of the history buffer, or the alarm-status page. It sits between the button debouncers and the display/history-memory datapath. It owns the history-buffer read handshake.

Parameters:
NPARAM, 4, number of monitored vital parameters selectable in live view
SELW, 2, width of parameter select (ceil log2 NPARAM)
AW, 3, history buffer address width (depth 2**AW)
DWELL, 13, clock cycles each history entry stays on display after its read is acknowledged
TW, 4, width of dwell/status-hold counters
SHOLD, 13, status page hold cycles (used only with STATUS_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
postop  in  1  post-op monitoring enabled (switch level)
tasto_change  in  1  debounced change button, level
tasto_hist  in  1  debounced history button, level
tasto_status  in  1  debounced status button, level
hist_count  in  AW+1  number of valid history entries (0..2**AW)
hist_rd_ack  in  1  history memory read acknowledge
mode  out  2  00 IDLE, 01 LIVE, 10 HIST, 11 STATUS
sel  out  SELW  live-view parameter select
hist_rd_req  out  1  history read request
hist_rd_addr  out  AW  history read address
hist_busy  out  1  high while mode==HIST

Behaviour:
- Reset (rst=0, async): mode=IDLE, sel=0, hist_rd_req=0, hist_rd_addr=0, hist_busy=0, edge registers=0, counters=0.
- Edge detect: each button level is registered. A rising edge gives a one-cycle internal pulse in the cycle after the level rises. Holding a button gives exactly one pulse.
- Simultaneous pulses: priority status > hist > change. Lower-priority pulses in the same cycle are dropped.
- postop=0 in any state: go to IDLE on the next edge. This drops hist_rd_req and resets sel to 0. The postop check has priority over all button pulses.
- IDLE: all buttons ignored. When postop=1, go to LIVE.
- LIVE:
  - change pulse: sel increments and wraps from NPARAM-1 to 0.
  - hist pulse with hist_count!=0: go to HIST with addr=0. With hist_count==0 the pulse is ignored.
  - status pulse: go to STATUS.
- HIST substates: REQ and DWELL.
  - REQ: hist_rd_req=1 and hist_rd_addr stays stable until hist_rd_ack=1 is sampled. An ack in the first request cycle is valid.
  - On ack: req drops next cycle and the dwell counter loads DWELL-1.
  - DWELL: counter decrements each cycle. At 0, if addr==hist_count-1, return to LIVE. Otherwise addr+1 and back to REQ.
  - hist pulse: abort to LIVE. req drops next cycle even if no ack was received.
  - status pulse: abort to STATUS.
  - change pulse: ignored; sel unchanged.
  - hist_count is sampled on HIST entry. Later changes are ignored for that playback.
- STATUS:
  - status pulse: return to LIVE.
  - hist and change pulses: ignored.
- sel is retained through HIST and STATUS.
- hist_busy is registered and equals (mode==HIST).

Optional Feature:
STATUS_TIMEOUT_EN
- Defined: a hold counter loads SHOLD-1 on STATUS entry. STATUS returns to LIVE automatically when the counter reaches 0, or earlier on a status pulse.
- Undefined: STATUS is left only by a status pulse or postop=0. No hold counter is synthesized.

Test Plan:
1. rst low mid-HIST with req=1 -> all outputs 0 immediately (async). After release with postop=1 -> mode=01 one cycle later.
2. LIVE, 5 change presses with NPARAM=4 -> sel sequence 1,2,3,0,1. A held button gives a single increment.
3. hist_count=3, hist pulse, memory acks 2 cycles after each req -> addrs 0,1,2 each shown 13 cycles after ack, then mode=01.
4. HIST at addr 1 with ack pending, hist pulse -> req=0 next cycle, mode=01, sel unchanged. Also: hist pulse with hist_count=0 -> mode stays 01.
5. Change, hist and status rising in the same cycle in LIVE -> mode=11, sel unchanged. postop=0 -> mode=00, sel=0.
6. STATUS_TIMEOUT_EN defined: enter STATUS -> auto return to 01 after 13 cycles. Undefined: mode stays 11 for 100 cycles until a status press.
